// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, owner encodings and read-tag layout for the RAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_P0   = 2'd1,
    OWNER_P1   = 2'd2
  } owner_e;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-port round-robin grant logic with owner override; purely combinational.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic [1:0] owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (owner)
      OWNER_P0: gnt = {1'b0, req[0]};
      OWNER_P1: gnt = {req[1], 1'b0};
      default: begin
        // On contention the port that was not granted last wins.
        if (req == 2'b11) gnt = rr_last ? 2'b01 : 2'b10;
        else              gnt = req;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the CPU (port 0) and the IO/LCD front panel (port 1),
// with registered RAM outputs, lockable ownership and a fixed-latency tagged read return.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned READ_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic          busy
);

  owner_e                     owner_q, owner_d;
  logic                       rr_last_q, rr_last_d;
  logic [AW-1:0]              mem_address_q, mem_address_d;
  logic [DW-1:0]              mem_data_q, mem_data_d;
  logic                       mem_wren_q, mem_wren_d;
  rd_tag_t [READ_LAT-1:0]     tag_q, tag_d;
  rd_tag_t                    new_tag;
  logic [1:0]                 gnt_c;

  rr_arb2 u_arb (
    .req     ({req1, req0}),
    .rr_last (rr_last_q),
    .owner   (owner_q),
    .gnt     (gnt_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q       <= OWNER_NONE;
      rr_last_q     <= 1'b1;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      tag_q         <= '0;
    end else begin
      owner_q       <= owner_d;
      rr_last_q     <= rr_last_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      tag_q         <= tag_d;
    end
  end

  // Ownership next state; an idle locked owner releases by dropping lock with req low.
  always_comb begin
    owner_d = owner_q;
    if (gnt_c[0])      owner_d = lock0 ? OWNER_P0 : OWNER_NONE;
    else if (gnt_c[1]) owner_d = lock1 ? OWNER_P1 : OWNER_NONE;
    else if (owner_q == OWNER_P0 && !req0 && !lock0) owner_d = OWNER_NONE;
    else if (owner_q == OWNER_P1 && !req1 && !lock1) owner_d = OWNER_NONE;
  end

  // Memory-side capture and read-tag pipe; writes enter the pipe as bubbles.
  always_comb begin
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    rr_last_d     = rr_last_q;
    new_tag       = '0;
    if (gnt_c[0]) begin
      mem_address_d = addr0;
      mem_data_d    = wdata0;
      mem_wren_d    = we0;
      rr_last_d     = 1'b0;
      new_tag       = '{valid: ~we0, port: 1'b0};
    end else if (gnt_c[1]) begin
      mem_address_d = addr1;
      mem_data_d    = wdata1;
      mem_wren_d    = we1;
      rr_last_d     = 1'b1;
      new_tag       = '{valid: ~we1, port: 1'b1};
    end
    tag_d = {tag_q[READ_LAT-2:0], new_tag};
  end

  // Output decode.
  always_comb begin
    gnt0        = gnt_c[0];
    gnt1        = gnt_c[1];
    rvalid0     = tag_q[READ_LAT-1].valid & ~tag_q[READ_LAT-1].port;
    rvalid1     = tag_q[READ_LAT-1].valid &  tag_q[READ_LAT-1].port;
    rdata       = mem_q;
    mem_address = mem_address_q;
    mem_data    = mem_data_q;
    mem_wren    = mem_wren_q;
    busy        = (owner_q != OWNER_NONE);
    for (int unsigned i = 0; i < READ_LAT; i++) busy = busy | tag_q[i].valid;
  end

endmodule
